// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU.
//   op codes     : OP_ADD .. OP_PASSB (110/111 reserved, produce zero)
//   FSM states   : S_IDLE, S_RUN, S_DONE
//   flag indices : bit positions of C/Z/V/N inside the packed flag register
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;
    localparam int NFLAGS = 4;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_digit.sv
// Combinational DIGIT-bit ALU slice: a ripple of 1-bit full-adder/logic cells.
//   a, b   : operand digits (b already inverted by the caller for SUB)
//   cin    : carry into bit 0
//   op     : operation code
//   y      : result digit
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed-overflow detection)
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [DIGIT-1:0] y,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin
        logic c;
        c     = cin;
        y     = '0;
        c_msb = cin;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                c_msb = c;
            end
            case (op)
                OP_ADD, OP_SUB: y[i] = a[i] ^ b[i] ^ c;
                OP_AND:         y[i] = a[i] & b[i];
                OP_OR:          y[i] = a[i] | b[i];
                OP_XOR:         y[i] = a[i] ^ b[i];
                OP_PASSB:       y[i] = b[i];
                default:        y[i] = 1'b0;
            endcase
            // Adder carry is always rippled; the top level ignores it for logic ops.
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: processes DIGIT bits per clock over WIDTH/DIGIT cycles,
// with valid/ready handshakes on input and output.
//   clk, reset          : clock; synchronous active-low reset
//   in_valid/in_ready   : operation handshake (a, b, aen, op)
//   out_valid/out_ready : result handshake (result, flag_c/z/v/n)
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for an operation, in_ready high
// S_RUN  | one digit per cycle through the slice, LSB digit first
// S_DONE | result and flags held, out_valid high until out_ready
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             aen,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh, result_r;
    logic               carry;
    logic [2:0]         op_r;
    logic [CNT_W-1:0]   cnt;
    logic [NFLAGS-1:0]  flags_r;

    logic [DIGIT-1:0]   dig_y;
    logic               dig_cout, dig_cmsb;
    logic               last_digit;
    logic [WIDTH-1:0]   res_next;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .cin   (carry),
        .op    (op_r),
        .y     (dig_y),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    assign last_digit = (cnt == CNT_W'(NDIG - 1));
    // New digit enters at the top; written as shifts so DIGIT==WIDTH needs no special case.
    assign res_next   = (res_sh >> DIGIT) | (WIDTH'(dig_y) << (WIDTH - DIGIT));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = reset;
                if (in_valid && reset) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_digit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            result_r <= '0;
            carry    <= 1'b0;
            op_r     <= OP_ADD;
            cnt      <= '0;
            flags_r  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh   <= aen ? a : '0;
                        b_sh   <= (op == OP_SUB) ? ~b : b;
                        carry  <= (op == OP_SUB);
                        op_r   <= op;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    carry  <= dig_cout;
                    cnt    <= cnt + 1'b1;
                    // Output register only changes once the whole word is known.
                    if (last_digit) begin
                        result_r        <= res_next;
                        flags_r[FLAG_C] <= is_arith(op_r) & dig_cout;
                        flags_r[FLAG_V] <= is_arith(op_r) & (dig_cmsb ^ dig_cout);
                        flags_r[FLAG_Z] <= (res_next == '0);
                        flags_r[FLAG_N] <= res_next[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_r;
    assign flag_c = flags_r[FLAG_C];
    assign flag_z = flags_r[FLAG_Z];
    assign flag_v = flags_r[FLAG_V];
    assign flag_n = flags_r[FLAG_N];

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: four instances (DIGIT=4,1,8,16) share stimulus and are
// checked against an arithmetic reference model.
module tb_alu_serial;

    localparam int W  = 16;
    localparam int ND = 4;
    localparam int DG [ND] = '{4, 1, 8, 16};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          aen = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    op = '0;

    logic          ir [ND];
    logic          ov [ND];
    logic          fc [ND];
    logic          fz [ND];
    logic          fv [ND];
    logic          fn [ND];
    logic [W-1:0]  res [ND];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        alu_serial #(.WIDTH(W), .DIGIT(DG[g])) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .a         (a),
            .b         (b),
            .aen       (aen),
            .op        (op),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .result    (res[g]),
            .flag_c    (fc[g]),
            .flag_z    (fz[g]),
            .flag_v    (fv[g]),
            .flag_n    (fn[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {N, V, Z, C, result}.
    function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic maen, input logic [2:0] mop);
        logic [16:0] s;
        logic [15:0] ea, r;
        logic        c, v;
        ea = maen ? ma : 16'h0;
        c  = 1'b0;
        v  = 1'b0;
        r  = 16'h0;
        s  = 17'h0;
        case (mop)
            3'd0: begin
                s = {1'b0, ea} + {1'b0, mb};
                r = s[15:0];
                c = s[16];
                v = (ea[15] == mb[15]) && (r[15] != ea[15]);
            end
            3'd1: begin
                s = {1'b0, ea} + {1'b0, ~mb} + 17'd1;
                r = s[15:0];
                c = s[16];
                v = (ea[15] != mb[15]) && (r[15] != ea[15]);
            end
            3'd2: r = ea & mb;
            3'd3: r = ea | mb;
            3'd4: r = ea ^ mb;
            3'd5: r = mb;
            default: r = 16'h0;
        endcase
        return {r[15], v, (r == 16'h0), c, r};
    endfunction

    function automatic logic all_ready();
        logic ok;
        ok = 1'b1;
        for (int g = 0; g < ND; g++) ok = ok & ir[g];
        return ok;
    endfunction

    function automatic logic [3:0] flags_of(input int g);
        return {fn[g], fv[g], fz[g], fc[g]};
    endfunction

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic taen,
                         input logic [2:0] top, input logic hold_valid);
        logic [19:0] e;
        int lat [ND];
        int waited;
        e = model(ta, tb_v, taen, top);
        waited = 0;
        while (!all_ready() && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("ready_timeout", 32'(waited < 40), 32'd1);
        a        = ta;
        b        = tb_v;
        aen      = taen;
        op       = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
        for (int g = 0; g < ND; g++) lat[g] = 0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < ND; g++)
                if (ov[g] && lat[g] == 0) lat[g] = k;
        end
        for (int g = 0; g < ND; g++) begin
            check($sformatf("latency d%0d op%0d", DG[g], top), 32'(lat[g]), 32'(W / DG[g]));
            check($sformatf("result d%0d op%0d", DG[g], top), 32'(res[g]), 32'(e[15:0]));
            check($sformatf("flags_nvzc d%0d op%0d", DG[g], top), 32'(flags_of(g)), 32'(e[19:16]));
        end
        // Hold out_ready low a while; outputs must not move and nothing new is accepted.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < ND; g++) begin
                check($sformatf("hold_valid d%0d", DG[g]), 32'(ov[g]), 32'd1);
                check($sformatf("hold_ready d%0d", DG[g]), 32'(ir[g]), 32'd0);
                check($sformatf("hold_result d%0d", DG[g]), 32'(res[g]), 32'(e[15:0]));
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int g = 0; g < ND; g++) begin
            check($sformatf("release_valid d%0d", DG[g]), 32'(ov[g]), 32'd0);
            check($sformatf("release_ready d%0d", DG[g]), 32'(ir[g]), 32'd1);
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int g = 0; g < ND; g++) begin
            check($sformatf("%s_valid d%0d", tag, DG[g]), 32'(ov[g]), 32'd0);
            check($sformatf("%s_result d%0d", tag, DG[g]), 32'(res[g]), 32'd0);
            check($sformatf("%s_flags d%0d", tag, DG[g]), 32'(flags_of(g)), 32'd0);
            check($sformatf("%s_ready d%0d", tag, DG[g]), 32'(ir[g]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++)
            check($sformatf("post_reset_ready d%0d", DG[g]), 32'(ir[g]), 32'd1);

        do_op(16'h7FFF, 16'h0001, 1'b1, 3'd0, 1'b0);
        do_op(16'h0005, 16'h0005, 1'b1, 3'd1, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b1, 3'd1, 1'b0);
        do_op(16'hBEEF, 16'h1234, 1'b0, 3'd0, 1'b0);
        do_op(16'h5555, 16'h0001, 1'b0, 3'd1, 1'b0);
        do_op(16'hF0F0, 16'hFF00, 1'b1, 3'd4, 1'b1);
        do_op(16'hA5A5, 16'h0F0F, 1'b1, 3'd2, 1'b0);
        do_op(16'hA5A5, 16'h0F0F, 1'b1, 3'd3, 1'b0);
        do_op(16'hA5A5, 16'hC3C3, 1'b1, 3'd5, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 3'd7, 1'b0);
        do_op(16'h1234, 16'h4321, 1'b1, 3'd6, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 3'd1, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b1, 3'd0, 1'b0);

        // Abort an ADD on its second RUN cycle.
        a        = 16'h1111;
        b        = 16'h2222;
        aen      = 1'b1;
        op       = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_cleared("midrun_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < ND; g++)
            check($sformatf("after_abort_ready d%0d", DG[g]), 32'(ir[g]), 32'd1);
        do_op(16'h0003, 16'h0004, 1'b1, 3'd0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            do_op(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
